// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared constants, access kinds and bus decode for mem_io_responder
package mem_io_pkg;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_UART_OFS = 3'h0;
  localparam logic [2:0] IO_CLK_OFS  = 3'h4;

  typedef enum logic [2:0] {
    RAM_RD,
    RAM_WR,
    UART_RD,
    UART_WR,
    CLK_RD,
    STOP_WR,
    IO_NOP
  } access_kind_e;

  // Only offsets 0x0 and 0x4..0x7 of the I/O window are live; everything else is a no-op.
  function automatic access_kind_e decode_access(input logic [17:0] addr, input logic wr);
    if (addr[17:16] != IO_SEL) return wr ? RAM_WR : RAM_RD;
    if (addr[15:3] != 13'd0) return IO_NOP;
    if (addr[2:0] == IO_UART_OFS) return wr ? UART_WR : UART_RD;
    if (addr[2] == IO_CLK_OFS[2]) begin
      if (!wr) return CLK_RD;
      return (addr[2:0] == IO_CLK_OFS) ? STOP_WR : IO_NOP;
    end
    return IO_NOP;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// rtl/mem_io_responder_byte_fifo.sv - pointer-based FIFO with extra wrap bit for full/empty
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full queue still accepts a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte-bus target: 128 KB RAM plus UART queues, cycle counter and stop flag
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    RAM_ADDR_W  = 17,
  parameter int    TX_DEPTH    = 16,
  parameter int    RX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic        tx_overflow
);

  localparam int TXCW      = $clog2(TX_DEPTH) + 1;
  localparam int RXCW      = $clog2(RX_DEPTH) + 1;
  localparam int RAM_WORDS = 1 << RAM_ADDR_W;

  logic [7:0]            ram [0:RAM_WORDS-1];
  logic [RAM_ADDR_W-1:0] ram_idx;
  access_kind_e          kind;
  logic [31:0]           counter;
  logic [23:0]           snapshot;
  logic                  unused_addr;

  logic            tx_push, tx_full, tx_empty;
  logic [7:0]      tx_din;
  logic [TXCW-1:0] tx_count;
  logic            rx_push, rx_full, rx_empty;
  logic [7:0]      rx_head;
  logic [RXCW-1:0] unused_rx_count;

  assign unused_addr = ^mem_a[31:18];
  assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
  assign kind        = decode_access(mem_a[17:0], mem_wr);

  // The stop write queues a 0x00 terminator, which bypasses the zero filter on ordinary UART writes.
  assign tx_push = ((kind == UART_WR) && (mem_dout != 8'h00)) || (kind == STOP_WR);
  assign tx_din  = (kind == STOP_WR) ? 8'h00 : mem_dout;
  assign rx_push = rx_valid && !rx_full;

  assign tx_valid       = !tx_empty;
  assign rx_ready       = !rx_full;
  assign io_buffer_full = (TXCW'(TX_DEPTH) - tx_count) <= TXCW'(FULL_MARGIN);

  byte_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (tx_din),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (rx_push),
    .pop   (kind == UART_RD),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (unused_rx_count)
  );

  always_ff @(posedge clk_in) begin
    if (kind == RAM_WR) ram[ram_idx] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din     <= 8'h00;
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
      counter     <= 32'd0;
      snapshot    <= 24'd0;
    end else begin
      if (!halt) counter <= counter + 32'd1;
      if (kind == STOP_WR) halt <= 1'b1;
      if (tx_push && tx_full && !tx_ready) tx_overflow <= 1'b1;
      case (kind)
        RAM_RD:  mem_din <= ram[ram_idx];
        UART_RD: mem_din <= rx_empty ? 8'h00 : rx_head;
        CLK_RD: begin
          // Byte 0 captures the upper bytes so a following 0x5..0x7 sequence sees one coherent value.
          case (mem_a[1:0])
            2'd0: begin
              mem_din  <= counter[7:0];
              snapshot <= counter[31:8];
            end
            2'd1:    mem_din <= snapshot[7:0];
            2'd2:    mem_din <= snapshot[15:8];
            default: mem_din <= snapshot[23:16];
          endcase
        end
        IO_NOP:  if (!mem_wr) mem_din <= 8'h00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - scoreboard bench for mem_io_responder
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic        tx_overflow;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  bit          rd_pending = 0;
  string       rd_tag;
  logic [31:0] tb_cnt;
  bit          tb_halt = 0;
  logic [31:0] snap;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .halt           (halt),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) tb_cnt <= 32'd0;
    else if (!tb_halt) tb_cnt <= tb_cnt + 32'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check_eq("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else check_eq("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
    end
    @(posedge clk_in);
    #1;
    if (rd_pending) begin
      check_eq(rd_tag, {24'd0, mem_din}, {24'd0, rd_q.pop_front()});
      rd_pending = 0;
    end
  endtask

  task automatic idle();
    mem_a  = 32'h0003_0008;
    mem_wr = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
    mem_a  = a;
    mem_wr = 1'b0;
    rd_q.push_back(exp);
    rd_tag     = tag;
    rd_pending = 1;
    tick();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d, input bit exp_tx);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    if (exp_tx) tx_q.push_back(d);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0; mem_a = 32'h0003_0008; mem_wr = 1'b0; mem_dout = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_mem_din", {24'd0, mem_din}, 32'd0);
    check_eq("rst_halt", {31'd0, halt}, 32'd0);
    check_eq("rst_ovf", {31'd0, tx_overflow}, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check_eq("rst_ibf", {31'd0, io_buffer_full}, 32'd0);
    rst_in = 1'b1;

    bus_wr(32'h0000_0010, 8'hA5, 0);
    bus_rd(32'h0000_0010, 8'hA5, "ram_rd_10");
    bus_wr(32'h0000_0020, 8'h77, 0);
    check_eq("ram_wr_hold", {24'd0, mem_din}, 32'hA5);
    bus_wr(32'h0001_FFFF, 8'h3C, 0);
    bus_rd(32'h0001_FFFF, 8'h3C, "ram_rd_top");
    bus_rd(32'h0000_0020, 8'h77, "ram_rd_20");

    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h41, 1);
    bus_wr(32'h0003_0000, 8'h00, 0);
    bus_wr(32'h0003_0000, 8'h42, 1);
    repeat (4) idle();
    check_eq("tx_drained1", tx_q.size(), 32'd0);
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_wr(32'h0003_0000, 8'h50 + 8'(i), i < 16);
      check_eq("tx_ibf", {31'd0, io_buffer_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
      check_eq("tx_ovf", {31'd0, tx_overflow}, (i == 16) ? 32'd1 : 32'd0);
    end
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h99, 1);
    check_eq("tx_full_pushpop_ibf", {31'd0, io_buffer_full}, 32'd1);
    repeat (20) idle();
    check_eq("tx_drained2", tx_q.size(), 32'd0);
    check_eq("tx_valid_empty", {31'd0, tx_valid}, 32'd0);
    check_eq("tx_ovf_sticky", {31'd0, tx_overflow}, 32'd1);

    rx_valid = 1'b1; rx_data = 8'h31;
    idle();
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000, 8'h31, "rx_rd1");
    bus_rd(32'h0003_0000, 8'h00, "rx_rd_empty");
    rx_valid = 1'b1; rx_data = 8'h62;
    bus_rd(32'h0003_0000, 8'h00, "rx_pop_empty_push");
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000, 8'h62, "rx_no_bypass");
    for (int i = 0; i < 16; i++) begin
      rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
      idle();
    end
    check_eq("rx_full_ready", {31'd0, rx_ready}, 32'd0);
    rx_data = 8'hEE;
    idle();
    rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) bus_rd(32'h0003_0000, 8'h80 + 8'(i), "rx_fill_order");
    bus_rd(32'h0003_0000, 8'h00, "rx_drop_when_full");
    check_eq("rx_ready_again", {31'd0, rx_ready}, 32'd1);

    repeat (300) idle();
    snap = tb_cnt;
    bus_rd(32'h0003_0004, snap[7:0],   "clk_b0");
    bus_rd(32'h0003_0005, snap[15:8],  "clk_b1");
    bus_rd(32'h0003_0006, snap[23:16], "clk_b2");
    bus_rd(32'h0003_0007, snap[31:24], "clk_b3");
    bus_rd(32'h0003_0001, 8'h00, "io_other_rd");
    bus_wr(32'h0003_0005, 8'h12, 0);
    check_eq("no_halt_ofs5", {31'd0, halt}, 32'd0);

    tx_q.push_back(8'h00);
    bus_wr(32'h0003_0004, 8'h5A, 0);
    check_eq("halt_set", {31'd0, halt}, 32'd1);
    tb_halt = 1;
    repeat (3) idle();
    check_eq("tx_terminator", tx_q.size(), 32'd0);
    snap = tb_cnt;
    repeat (5) idle();
    bus_rd(32'h0003_0004, snap[7:0],   "frz_b0");
    bus_rd(32'h0003_0005, snap[15:8],  "frz_b1");
    bus_rd(32'h0003_0006, snap[23:16], "frz_b2");
    bus_rd(32'h0003_0007, snap[31:24], "frz_b3");

    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_wr(32'h0003_0000, 8'h60 + 8'(i), 1);
    tx_ready = 1'b1;
    idle();
    bus_rd(32'h0000_0010, 8'hA5, "pre_rst_rd");
    check_eq("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
    rst_in = 1'b0;
    #2;
    check_eq("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("arst_mem_din", {24'd0, mem_din}, 32'd0);
    check_eq("arst_halt", {31'd0, halt}, 32'd0);
    check_eq("arst_ovf", {31'd0, tx_overflow}, 32'd0);
    tx_q.delete();
    tb_halt = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    bus_rd(32'h0000_0010, 8'hA5, "ram_retained");
    bus_rd(32'h0001_FFFF, 8'h3C, "ram_retained_top");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
